// File: rtl/multi_cycle_controller.sv
// Moore-style multi-cycle RISC-V control FSM: sequences fetch/decode/execute/writeback per opcode.
// Optional MC_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in HALT instead of retiring as a NOP.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       halt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_r;
    state_t next_s;
    logic   mem_write_s;
    logic   reg_write_s;
    logic   func7_unused_s;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_decode = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  alu_decode = ALU_AND;
            3'b110:  alu_decode = ALU_OR;
            3'b100:  alu_decode = ALU_XOR;
            3'b010:  alu_decode = ALU_SLT;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = ~z;
            3'b100:  branch_taken = l;
            3'b101:  branch_taken = ~l;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Only func7[5] distinguishes add/sub; the remaining bits are decoded elsewhere in the core.
    assign func7_unused_s = ^{func7[6], func7[4:0]};

    // State register, forced to FETCH asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_s = S_MEMADR;
                    OP_RTYPE:          next_s = S_EXECR;
                    OP_ITYPE:          next_s = S_EXECI;
                    OP_BRANCH:         next_s = S_BRANCH;
                    OP_JAL:            next_s = S_JAL;
                    OP_JALR:           next_s = S_JALR;
                    OP_LUI:            next_s = S_LUI;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           next_s = S_HALT;
`else
                    default:           next_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_STORE) begin
                    next_s = S_MEMWRITE;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMREAD:  next_s = S_MEMWB;
            S_EXECR:    next_s = S_ALUWB;
            S_EXECI:    next_s = S_ALUWB;
            S_JAL:      next_s = S_ALUWB;
            S_JALR:     next_s = S_JALRLINK;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:     next_s = S_HALT;
`endif
            default:    next_s = S_FETCH;
        endcase
    end

    // Output decode from the current state (plus instruction fields where the state needs them).
    always_comb begin
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUControl  = ALU_ADD;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 3'b000;
        reg_write_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(func3, func7[5]);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(func3, 1'b0);
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = branch_taken(func3, zero, lt);
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_JALRLINK: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                reg_write_s = 1'b1;
            end
            S_LUI: begin
                ImmSrc      = 3'b100;
                ResultSrc   = 2'b11;
                reg_write_s = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    // Store and register-write strobes must never fire while reset is held.
    assign MemWrite = mem_write_s & rst;
    assign RegWrite = reg_write_s & rst;
    assign state    = state_r;

`ifdef MC_ILLEGAL_TRAP_EN
    assign halt = (state_r == S_HALT) & rst;
`else
    assign halt = 1'b0;
`endif

endmodule
